// File: rtl/multiphase_clock_divider.sv
// Programmable multiphase clock divider: NUM_PHASES equally stepped 50 % duty phases
// derived from clk, with glitch-free reconfiguration on phase-0 period boundaries.
module multiphase_clock_divider #(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 2,
  parameter int DEFAULT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_W-1:0]      cfg_half,
  input  logic [CNT_W-1:0]      cfg_step,
  output logic                  cfg_error,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic                  locked,
  output logic                  period_tick
);

  localparam int PW = CNT_W + 1;
  localparam int IW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] act_half;
  logic [CNT_W-1:0] act_step;
  logic [CNT_W-1:0] shd_half;
  logic [CNT_W-1:0] shd_step;
  logic             shd_full;
  logic [PW-1:0]    cnt     [NUM_PHASES];
  logic [PW-1:0]    cnt_inc [NUM_PHASES];
  logic [PW-1:0]    off_prev;
  logic [IW-1:0]    load_idx;

  logic [PW-1:0]    period;
  logic [PW-1:0]    half_ext;
  logic [PW:0]      off_sum;
  logic [PW-1:0]    off_cur;
  logic [PW-1:0]    cnt_init;
  logic             cfg_take;
  logic             cfg_ok;
  logic             boundary;
  logic             load_last;

  assign period    = {act_half, 1'b0};
  assign half_ext  = {1'b0, act_half};
  assign cfg_ready = ~shd_full;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_half != '0) && ({1'b0, cfg_step} < {cfg_half, 1'b0});
  assign boundary  = (state == RUN) && (cnt[0] == period - ONE);
  assign load_last = (load_idx == IW'(NUM_PHASES - 1));

  // Offsets are built one phase per LOAD cycle; the sum needs one spare bit before the wrap.
  assign off_sum  = {1'b0, off_prev} + {2'b00, act_step};
  assign off_cur  = (load_idx == '0) ? '0 :
                    (off_sum >= {1'b0, period}) ? PW'(off_sum - {1'b0, period}) :
                    off_sum[PW-1:0];
  assign cnt_init = (off_cur == '0) ? '0 : period - off_cur;

  always_comb begin
    for (int k = 0; k < NUM_PHASES; k++) begin
      cnt_inc[k] = (cnt[k] == period - ONE) ? '0 : cnt[k] + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      act_half    <= CNT_W'(DEFAULT_HALF);
      act_step    <= CNT_W'(DEFAULT_STEP);
      shd_half    <= '0;
      shd_step    <= '0;
      shd_full    <= 1'b0;
      off_prev    <= '0;
      load_idx    <= '0;
      phase_out   <= '0;
      locked      <= 1'b0;
      period_tick <= 1'b0;
      cfg_error   <= 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      cfg_error <= cfg_take && !cfg_ok;

      // Outside IDLE an accepted config waits in the shadow for the next period boundary.
      if (cfg_take && cfg_ok && state != IDLE) begin
        shd_half <= cfg_half;
        shd_step <= cfg_step;
        shd_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          phase_out   <= '0;
          locked      <= 1'b0;
          period_tick <= 1'b0;
          load_idx    <= '0;
          if (shd_full) begin
            act_half <= shd_half;
            act_step <= shd_step;
            shd_full <= 1'b0;
          end else if (cfg_take && cfg_ok) begin
            act_half <= cfg_half;
            act_step <= cfg_step;
          end
          if (enable) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          cnt[load_idx] <= cnt_init;
          off_prev      <= off_cur;
          period_tick   <= 1'b0;
          if (load_last) begin
            state    <= RUN;
            load_idx <= '0;
            locked   <= 1'b1;
            // The last phase's counter is being written this cycle, so use its fresh value.
            for (int k = 0; k < NUM_PHASES; k++) begin
              phase_out[k] <= (((k == NUM_PHASES - 1) ? cnt_init : cnt[k]) < half_ext);
            end
          end else begin
            load_idx  <= load_idx + IW'(1);
            locked    <= 1'b0;
            phase_out <= '0;
          end
        end

        RUN: begin
          if (boundary && !enable) begin
            state       <= IDLE;
            phase_out   <= '0;
            locked      <= 1'b0;
            period_tick <= 1'b0;
          end else if (boundary && shd_full) begin
            act_half    <= shd_half;
            act_step    <= shd_step;
            shd_full    <= 1'b0;
            state       <= LOAD;
            phase_out   <= '0;
            locked      <= 1'b0;
            period_tick <= 1'b0;
          end else begin
            for (int k = 0; k < NUM_PHASES; k++) begin
              cnt[k]       <= cnt_inc[k];
              phase_out[k] <= (cnt_inc[k] < half_ext);
            end
            locked      <= 1'b1;
            period_tick <= (cnt_inc[0] == period - ONE);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
